// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide unit: sequencer states, op codes
// and default iteration counts also used by the datapath.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MULT_STEPS_DEF = 32;
  localparam int DIV_STEPS_DEF  = 34;
  localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/step_counter.sv
// Saturating iteration counter: counts up while enabled and stops at the
// terminal value, so it can never wrap.
module step_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  assign at_term = (count == term);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the multiply/divide unit: handshake in, load pulse,
// per-iteration step enables, and a held result-valid with abort support.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEF,
  parameter int DIV_STEPS  = DIV_STEPS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             div_zero_i,
  input  logic             abort_i,
  input  logic             result_ready_i,
  output logic             ready_o,
  output logic             load_o,
  output logic             step_o,
  output logic [CNT_W-1:0] step_count_o,
  output logic             last_step_o,
  output logic             done_o,
  output logic             exception_o,
  output logic             busy_o,
  output logic             op_q_o
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_e           state_q, state_d;
  logic             op_q, zero_q;
  logic             accept;
  logic [CNT_W-1:0] count, term;
  logic             at_term;

  // Combinational ready lets a consumer accepting a result issue the next op
  // in the same cycle, so DONE turns straight into LOAD.
  assign ready_o = ~abort_i & ((state_q == ST_IDLE) |
                               ((state_q == ST_DONE) & result_ready_i));
  assign accept  = start_i & ready_o;
  assign term    = (op_q == OP_DIV) ? DIV_LAST : MULT_LAST;

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_LOAD;
        ST_LOAD: state_d = zero_q ? ST_DONE : ST_RUN;
        ST_RUN:  if (at_term) state_d = ST_DONE;
        ST_DONE: begin
          if (accept)              state_d = ST_LOAD;
          else if (result_ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_i;
        zero_q <= div_zero_i & (op_i == OP_DIV);
      end
    end
  end

  step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((state_q == ST_IDLE) | (state_q == ST_LOAD)),
    .enable  (state_q == ST_RUN),
    .term    (term),
    .count   (count),
    .at_term (at_term)
  );

  // The register may still hold the previous op's last index in LOAD.
  assign step_count_o = ((state_q == ST_RUN) | (state_q == ST_DONE)) ? count : '0;
  assign load_o       = (state_q == ST_LOAD);
  assign step_o       = (state_q == ST_RUN);
  assign last_step_o  = (state_q == ST_RUN) & at_term;
  assign done_o       = (state_q == ST_DONE);
  assign exception_o  = (state_q == ST_DONE) & zero_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign op_q_o       = op_q;

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

- Parametrised control sequencer for the multiply/divide unit.
- Accepts an operation request through a ready/valid handshake, pulses the datapath load, then drives one step enable per iteration for a mode-dependent step count.
- Holds a result-valid flag until the consumer accepts it.
- Supersedes the fixed 34-state divide step counter and adds:
  - separate multiply/divide step counts;
  - back-to-back issue;
  - abort;
  - a divide-by-zero early exit.

## Interface
Parameters:
- MULT_STEPS, 32, RUN cycles for a multiply (≥1)
- DIV_STEPS, 34, RUN cycles for a divide (≥1)
- CNT_W, 6, step counter width; 2^CNT_W ≥ max(MULT_STEPS, DIV_STEPS)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  operation request; accepted on a clock edge where start_i & ready_o
- op_i  in  1  0 = multiply, 1 = divide; sampled with start
- div_zero_i  in  1  divisor is zero; sampled with start, ignored for multiply
- abort_i  in  1  cancel any operation in flight
- result_ready_i  in  1  consumer accepts the result
- ready_o  out  1  request can be accepted this cycle
- load_o  out  1  one-cycle datapath operand-load pulse
- step_o  out  1  datapath iteration enable
- step_count_o  out  CNT_W  index of the current step
- last_step_o  out  1  final RUN cycle
- done_o  out  1  result valid
- exception_o  out  1  divide-by-zero; qualified by done_o
- busy_o  out  1  state ≠ IDLE
- op_q_o  out  1  latched op_i

## Operation
States:
- IDLE
- LOAD
- RUN
- DONE

Transitions:
- IDLE → LOAD on accept; latch op_q and zero_q (= div_zero_i & op_i).
- LOAD → DONE if zero_q, else → RUN. Clear the counter in both cases.
- RUN: count increments each cycle. When count = N−1 → DONE, where N = MULT_STEPS or DIV_STEPS selected by op_q.
- DONE → LOAD on accept (back-to-back issue); latch the new op.
- DONE → IDLE if result_ready_i without start_i.
- DONE otherwise holds.
- abort_i in any state → IDLE next edge.
  - abort_i overrides start_i and result_ready_i.
  - No done_o is produced for the aborted operation.
  - abort_i in IDLE has no effect and blocks acceptance that cycle.

Outputs:
- ready_o = ~abort_i & (IDLE | (DONE & result_ready_i)). This is a combinational path from result_ready_i and abort_i.
- load_o = LOAD.
- step_o = RUN.
- last_step_o = RUN & count = N−1.
- done_o = DONE.
- exception_o = DONE & zero_q.
- step_count_o = counter value.
  - Holds its value in DONE.
  - Reads 0 in IDLE and LOAD.

Counter rules:
- The counter never wraps. Its terminal compare is against N−1 only.
- Step counts are compile-time constants; no runtime override.

## Timing
Reset values (asynchronous assertion, release synchronous to clock):
- state IDLE, count 0, op_q 0, zero_q 0.
- ready_o 1 (when abort_i is low); all other outputs 0.
- Reset mid-operation discards the operation; no done_o.

Latency, with acceptance at edge E:
- load_o is high in cycle E+1.
- step_o is high in cycles E+2 … E+1+N.
- done_o rises at E+2+N.
- Divide-by-zero: done_o and exception_o rise at E+2, with no step_o pulses.

Handshake and throughput:
- done_o stays high until the edge where result_ready_i is sampled high.
- Back-to-back issue gives one operation per N+2 cycles.
- The DONE→LOAD turnaround inserts no IDLE cycle.

## Structure
- multdiv_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - OP_MULT/OP_DIV constants;
  - default step-count constants, shared with the multdiv datapath.
- One sub-module, step_counter, parametrised by CNT_W:
  - inputs: clear, enable, terminal value;
  - outputs: count, terminal flag;
  - asynchronous active-low reset.
- The FSM and output decode live in multdiv_sequencer.

## Test plan
- Reset, then a multiply: start_i=1, op_i=0 → load_o at cycle 1; step_o for 32 cycles with step_count_o 0…31; last_step_o only at 31; done_o at cycle 34, held until result_ready_i.
- Divide with result_ready_i tied high and start_i held → done_o for one cycle every 36 cycles; load_o in the cycle after each done_o; ready_o never low for more than 35 cycles.
- Divide with div_zero_i=1 → done_o=1 and exception_o=1 at cycle 2, with zero step_o; div_zero_i=1 with op_i=0 → normal 32-step multiply, exception_o=0.
- abort_i at RUN step 10, then abort_i asserted simultaneously with result_ready_i in DONE → IDLE next edge each time; no done_o for the first case; ready_o=0 in abort cycles; start_i during abort is ignored.
- reset_n pulsed low mid-RUN, between clock edges → outputs go to reset values immediately; a fresh start_i afterwards gives the full N+2 latency.
- Non-default parameters (MULT_STEPS=1, DIV_STEPS=3, CNT_W=2) → one-step multiply has last_step_o in its only RUN cycle; divide count runs 0,1,2 then DONE.
